// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_fetch_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          SKID_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Only 32-bit encodings (low bits 2'b11) are accepted by this core.
    function automatic logic is_illegal_encoding(input logic [31:0] instr);
        return instr[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch entries absorbing ROM returns while decode is stalled.
module fetch_skid_fifo
    import riscv_fetch_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);

    logic         rd_ptr_reg;
    logic         wr_ptr_reg;
    logic [1:0]   count_reg;
    fetch_entry_t slot_q [SKID_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_slot
            fetch_entry_t slot_reg;
            always_ff @(posedge CLK) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    slot_reg <= push_entry;
                end
            end
            assign slot_q[gi] = slot_reg;
        end
    endgenerate

    // A push and pop at count 2 is safe: the head is read before the slot is overwritten.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && !clear && pop) begin
            assert (count_reg != 2'd0);
        end
    end

    assign head  = slot_q[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == 2'd0);
    assign full  = (count_reg == 2'd2);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: ROM request issue, skid buffering and the IF/ID register.
// Optional build macro FETCH_ILLEGAL_CHECK_EN replaces non-32-bit encodings with a NOP.
module fetch_stage
    import riscv_fetch_pkg::*;
#(
    parameter int          XLEN      = riscv_fetch_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = riscv_fetch_pkg::NOP_INSTR
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ce,
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            flush,
    output logic            rom_en,
    output logic [XLEN-1:0] rom_addr,
    input  logic [XLEN-1:0] rom_data,
    output logic            pc_hold,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic            if_id_valid,
    output logic            if_id_illegal
);

    logic         inflight_reg;
    logic [31:0]  req_pc_reg;
    logic [31:0]  instr_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  pc4_reg;
    logic         valid_reg;
    logic         illegal_reg;

    logic [1:0]   skid_count;
    logic         skid_empty;
    logic         skid_full;
    logic         skid_push;
    logic         skid_pop;
    fetch_entry_t skid_head;
    fetch_entry_t arrive_entry;
    fetch_entry_t load_entry;
    logic         load_en;
    logic         load_illegal;
    logic [31:0]  load_instr;
    logic [2:0]   occupancy;
    logic         issue_ok;

    // Outstanding work includes the read whose data is returning this cycle.
    assign occupancy = {1'b0, skid_count} + {2'b00, inflight_reg};
    assign issue_ok  = !stall || (occupancy < 3'd2);
    assign rom_en    = ce && issue_ok && !flush && !RESET;
    assign pc_hold   = ce && !issue_ok && !flush && !RESET;
    assign rom_addr  = pc;

    assign arrive_entry = '{pc: req_pc_reg, instr: rom_data};
    assign skid_pop     = !flush && !stall && !skid_empty;
    assign skid_push    = !flush && inflight_reg && (stall || !skid_empty);
    assign load_en      = !flush && !stall && (!skid_empty || inflight_reg);
    assign load_entry   = skid_empty ? arrive_entry : skid_head;

`ifdef FETCH_ILLEGAL_CHECK_EN
    assign load_illegal = is_illegal_encoding(load_entry.instr);
`else
    assign load_illegal = 1'b0;
`endif
    assign load_instr = load_illegal ? NOP_INSTR : load_entry.instr;

    fetch_skid_fifo u_skid (
        .CLK        (CLK),
        .RESET      (RESET),
        .clear      (flush),
        .push       (skid_push),
        .pop        (skid_pop),
        .push_entry (arrive_entry),
        .head       (skid_head),
        .count      (skid_count),
        .empty      (skid_empty),
        .full       (skid_full)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            inflight_reg <= 1'b0;
            req_pc_reg   <= 32'd0;
            instr_reg    <= NOP_INSTR;
            pc_reg       <= 32'd0;
            pc4_reg      <= 32'd4;
            valid_reg    <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            inflight_reg <= rom_en;
            if (rom_en) begin
                req_pc_reg <= pc;
            end
            if (flush) begin
                instr_reg   <= NOP_INSTR;
                valid_reg   <= 1'b0;
                illegal_reg <= 1'b0;
            end else if (!stall) begin
                if (load_en) begin
                    instr_reg   <= load_instr;
                    pc_reg      <= load_entry.pc;
                    pc4_reg     <= load_entry.pc + 32'd4;
                    valid_reg   <= 1'b1;
                    illegal_reg <= load_illegal;
                end else begin
                    instr_reg   <= NOP_INSTR;
                    valid_reg   <= 1'b0;
                    illegal_reg <= 1'b0;
                end
            end
        end
    end

    // The issue rule must keep a stalled push away from a full skid.
    always_ff @(posedge CLK) begin
        if (!RESET && skid_push && !skid_pop) begin
            assert (!skid_full);
        end
    end

    assign if_id_instr   = instr_reg;
    assign if_id_pc      = pc_reg;
    assign if_id_pc4     = pc4_reg;
    assign if_id_valid   = valid_reg;
    assign if_id_illegal = illegal_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage against a single-queue reference model.
module tb_fetch_stage;
    import riscv_fetch_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, ce, stall, flush;
    logic [31:0] pc, rom_addr, rom_data;
    logic        rom_en, pc_hold;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc4;
    logic        if_id_valid, if_id_illegal;

    always #5 CLK = ~CLK;

    fetch_stage dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .ce            (ce),
        .pc            (pc),
        .stall         (stall),
        .flush         (flush),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .pc_hold       (pc_hold),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .if_id_illegal (if_id_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ill;
    } exp_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    exp_t         exp_q[$];
    fetch_entry_t pend_q[$];

    function automatic logic [31:0] rom_func(input logic [31:0] a);
        if (a == 32'h10) return 32'h0000_0000;
        return a[3] ? (a | 32'h100) : (a | 32'h103);
    endfunction

    function automatic exp_t expect_of(input fetch_entry_t e);
        exp_t r;
        r.pc    = e.pc;
        r.instr = e.instr;
        r.ill   = 1'b0;
`ifdef FETCH_ILLEGAL_CHECK_EN
        if (e.instr[1:0] != 2'b11) begin
            r.instr = NOP_INSTR;
            r.ill   = 1'b1;
        end
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // ROM with one-cycle latency; garbage when not strobed.
    always @(posedge CLK) begin
        if (rom_en) rom_data <= rom_func(rom_addr);
        else        rom_data <= $urandom;
    end

    // Monitor: compares IF/ID against the scoreboard after every edge.
    logic        s_rst, s_flush, s_stall;
    logic [31:0] prev_pc, prev_pc4, prev_instr;
    logic        prev_valid, prev_ill;
    exp_t        got;

    always @(posedge CLK) begin
        s_rst   = RESET;
        s_flush = flush;
        s_stall = stall;
        #2;
        if (s_rst) begin
            check("reset_instr", if_id_instr, NOP_INSTR);
            check("reset_pc", if_id_pc, 32'd0);
            check("reset_pc4", if_id_pc4, 32'd4);
            check("reset_valid", 32'(if_id_valid), 32'd0);
            check("reset_illegal", 32'(if_id_illegal), 32'd0);
        end else if (s_flush || !s_stall) begin
            if (if_id_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid_pc", if_id_pc, 32'hxxxx_xxxx);
                end else begin
                    got = exp_q.pop_front();
                    $display("deliver pc=%h instr=%h ill=%0d", if_id_pc, if_id_instr, if_id_illegal);
                    check("if_id_pc", if_id_pc, got.pc);
                    check("if_id_pc4", if_id_pc4, got.pc + 32'd4);
                    check("if_id_instr", if_id_instr, got.instr);
                    check("if_id_illegal", 32'(if_id_illegal), 32'(got.ill));
                end
            end else begin
                check("bubble_instr", if_id_instr, NOP_INSTR);
                check("bubble_illegal", 32'(if_id_illegal), 32'd0);
                check("bubble_pc_kept", if_id_pc, prev_pc);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check("missing_delivery_pc", 32'hxxxx_xxxx, got.pc);
                end
            end
        end else begin
            check("stall_hold_pc", if_id_pc, prev_pc);
            check("stall_hold_instr", if_id_instr, prev_instr);
            check("stall_hold_valid", 32'(if_id_valid), 32'(prev_valid));
        end
        prev_pc    = if_id_pc;
        prev_pc4   = if_id_pc4;
        prev_instr = if_id_instr;
        prev_valid = if_id_valid;
        prev_ill   = if_id_illegal;
    end

    // Driver plus reference model: pend_q holds every issued, undelivered fetch in order.
    localparam int NCYC = 3000;
    logic        exp_issue, exp_hold;
    logic [31:0] pcv;
    int          stall_left;

    initial begin
        RESET = 1'b1; ce = 1'b0; stall = 1'b0; flush = 1'b0; pc = 32'd0;
        pcv = 32'd0; stall_left = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            #1;
            exp_issue = ce && (!stall || pend_q.size() < 2) && !flush && !RESET;
            exp_hold  = ce && !(!stall || pend_q.size() < 2) && !flush && !RESET;
            check("rom_en", 32'(rom_en), 32'(exp_issue));
            check("pc_hold", 32'(pc_hold), 32'(exp_hold));
            if (exp_issue) check("rom_addr", rom_addr, pc);

            @(posedge CLK);
            if (RESET || flush) begin
                pend_q.delete();
            end else if (!stall && pend_q.size() > 0) begin
                exp_q.push_back(expect_of(pend_q.pop_front()));
            end
            if (exp_issue) pend_q.push_back('{pc: pc, instr: rom_func(pc)});

            if (RESET)          pcv = 32'd0;
            else if (flush)     begin
                case ($urandom_range(0, 2))
                    0:       pcv = 32'h40;
                    1:       pcv = 32'hFFFF_FFF8;
                    default: pcv = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                endcase
            end else if (exp_issue) pcv = pcv + 32'd4;

            #1;
            pc = pcv;
            if (cyc < 3) begin
                RESET = 1'b1; ce = 1'b1; stall = 1'b0; flush = 1'b0;
            end else if (cyc < 15 || cyc >= NCYC - 10) begin
                RESET = 1'b0; ce = (cyc < 15); stall = 1'b0; flush = 1'b0;
            end else begin
                if (stall_left > 0) stall_left--;
                else if ($urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 5);
                stall = (stall_left > 0);
                ce    = ($urandom_range(0, 9) != 0);
                flush = ($urandom_range(0, 24) == 0);
                RESET = ($urandom_range(0, 299) == 0);
            end
        end
        #5;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
